// File: rtl/painter_pkg.sv
// painter_pkg: shared types and constants for the sprite painter.
//   state_t   - painter frame FSM states
//   sprite_t  - source rectangle in the sprite sheet (x, y, w, h)
//   pos_t     - signed destination position in the framebuffer
//   lin_addr  - row-major linear address helper used for ROM and framebuffer
package painter_pkg;

    localparam int RENDER_SLOTS    = 32;
    localparam int FB_WIDTH_DEF    = 1280;
    localparam int FB_HEIGHT_DEF   = 300;
    localparam int SHEET_WIDTH_DEF = 2446;
    localparam int PIXEL_BITS      = 2;

    localparam int ADDR_W  = 19;
    localparam int COORD_W = 13;
    localparam int SLOT_W  = 5;
    localparam int DIM_W   = 8;
    localparam int SRC_W   = 12;

    localparam logic [PIXEL_BITS-1:0] TRANSPARENT = '0;
    localparam logic [PIXEL_BITS-1:0] BG_COLOR    = 2'd1;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAW, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [SRC_W-1:0] x;
        logic [SRC_W-1:0] y;
        logic [DIM_W-1:0] w;
        logic [DIM_W-1:0] h;
    } sprite_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } pos_t;

    function automatic logic [ADDR_W-1:0] lin_addr(input int row, input int col, input int pitch);
        int a;
        a = row * pitch + col;
        return ADDR_W'(a);
    endfunction

endpackage

// File: rtl/sprite_blitter.sv
// sprite_blitter: walks one latched sprite slot pixel by pixel.
//   go        in   level, high for every DRAW cycle of the slot
//   spr, pos  in   latched source rectangle and destination position
//   rom_addr  out  sheet address of the pixel issued this cycle (0 when idle)
//   rom_data  in   ROM pixel, valid one cycle after rom_addr
//   done      out  high on the cycle the last pixel of the slot is issued
//   wr_en/wr_addr/wr_data out  write request from the clip/transparency stage
module sprite_blitter
    import painter_pkg::*;
#(
    parameter int FB_WIDTH    = FB_WIDTH_DEF,
    parameter int FB_HEIGHT   = FB_HEIGHT_DEF,
    parameter int SHEET_WIDTH = SHEET_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  sprite_t               spr,
    input  pos_t                  pos,
    input  logic [PIXEL_BITS-1:0] rom_data,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  done,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [PIXEL_BITS-1:0] wr_data
);

    localparam logic signed [COORD_W-1:0] FB_W_S = COORD_W'(FB_WIDTH);
    localparam logic signed [COORD_W-1:0] FB_H_S = COORD_W'(FB_HEIGHT);

    function automatic logic on_screen(input logic signed [COORD_W-1:0] x,
                                       input logic signed [COORD_W-1:0] y);
        return !x[COORD_W-1] && !y[COORD_W-1] && (x < FB_W_S) && (y < FB_H_S);
    endfunction

    logic [DIM_W-1:0]          cx_p0, cy_p0;
    logic                      last_col, last_row;
    logic                      vld_p1;
    logic signed [COORD_W-1:0] px_p1, py_p1;

    // ---- stage p0: pixel issue (counters, ROM address) ----
    assign last_col = (cx_p0 == spr.w - 8'd1);
    assign last_row = (cy_p0 == spr.h - 8'd1);
    assign done     = go && last_col && last_row;
    assign rom_addr = go ? lin_addr(int'(spr.y) + int'(cy_p0), int'(spr.x) + int'(cx_p0), SHEET_WIDTH)
                         : '0;

    always_ff @(posedge clk) begin
        if (rst || !go) begin
            cx_p0 <= '0;
            cy_p0 <= '0;
        end else if (last_col) begin
            cx_p0 <= '0;
            cy_p0 <= last_row ? '0 : cy_p0 + 8'd1;
        end else begin
            cx_p0 <= cx_p0 + 8'd1;
        end
    end

    // ---- stage p1: ROM data arrives, clip and transparency test ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= go;
    end

    always_ff @(posedge clk) begin
        px_p1 <= pos.x + $signed({{(COORD_W-DIM_W){1'b0}}, cx_p0});
        py_p1 <= pos.y + $signed({{(COORD_W-DIM_W){1'b0}}, cy_p0});
    end

    assign wr_en   = vld_p1 && (rom_data != TRANSPARENT) && on_screen(px_p1, py_p1);
    assign wr_addr = lin_addr(int'(py_p1), int'(px_p1), FB_WIDTH);
    assign wr_data = rom_data;

endmodule

// File: rtl/sprite_painter.sv
// sprite_painter: on each accepted start, clears the framebuffer to BG_COLOR and then
// blits every non-empty render slot in ascending order, one pixel per cycle.
//   clk, rst          clock, synchronous active-high reset
//   start             frame request pulse, accepted only in IDLE/DONE
//   sprite, pos       per-slot source rectangle and destination, sampled one slot at a time
//   rom_addr/rom_data sprite ROM port (one-cycle read latency)
//   fb_addr/fb_data/fb_we  registered framebuffer write port
//   busy              high from accepted start until the frame completes
//   painter_finished  level, high once the frame is complete
module sprite_painter
    import painter_pkg::*;
#(
    parameter int FB_WIDTH    = FB_WIDTH_DEF,
    parameter int FB_HEIGHT   = FB_HEIGHT_DEF,
    parameter int SHEET_WIDTH = SHEET_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  sprite_t               sprite [RENDER_SLOTS],
    input  pos_t                  pos    [RENDER_SLOTS],
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [PIXEL_BITS-1:0] rom_data,
    output logic [ADDR_W-1:0]     fb_addr,
    output logic [PIXEL_BITS-1:0] fb_data,
    output logic                  fb_we,
    output logic                  busy,
    output logic                  painter_finished
);

    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RENDER_SLOTS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [SLOT_W-1:0]   slot;
    sprite_t             cur_spr;
    pos_t                cur_pos;
    logic                slot_empty;
    logic                blit_go, blit_done, blit_we;
    logic [ADDR_W-1:0]   blit_addr;
    logic [PIXEL_BITS-1:0] blit_data;

    assign slot_empty = (sprite[slot].w == '0) || (sprite[slot].h == '0);
    assign blit_go    = (state == DRAW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            painter_finished <= 1'b0;
            clr_cnt          <= '0;
            slot             <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= CLEAR;
                        busy             <= 1'b1;
                        painter_finished <= 1'b0;
                        clr_cnt          <= '0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state <= LOAD;
                        slot  <= '0;
                    end
                end
                LOAD: begin
                    if (!slot_empty)             state <= DRAW;
                    else if (slot == LAST_SLOT)  state <= DRAIN;
                    else                         slot  <= slot + 1'b1;
                end
                DRAW: begin
                    if (blit_done) begin
                        if (slot == LAST_SLOT) begin
                            state <= DRAIN;
                        end else begin
                            slot  <= slot + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DRAIN: begin
                    state            <= DONE;
                    busy             <= 1'b0;
                    painter_finished <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot snapshot: runner may change the arrays mid-frame, only this copy is drawn.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            cur_spr <= sprite[slot];
            cur_pos <= pos[slot];
        end
    end

    sprite_blitter #(
        .FB_WIDTH   (FB_WIDTH),
        .FB_HEIGHT  (FB_HEIGHT),
        .SHEET_WIDTH(SHEET_WIDTH)
    ) u_blitter (
        .clk     (clk),
        .rst     (rst),
        .go      (blit_go),
        .spr     (cur_spr),
        .pos     (cur_pos),
        .rom_data(rom_data),
        .rom_addr(rom_addr),
        .done    (blit_done),
        .wr_en   (blit_we),
        .wr_addr (blit_addr),
        .wr_data (blit_data)
    );

    // ---- output register: clear writes or blit writes ----
    // Address/data only move on a write so the port stays quiet between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else if (state == CLEAR) begin
            fb_we   <= 1'b1;
            fb_addr <= clr_cnt;
            fb_data <= BG_COLOR;
        end else begin
            fb_we <= blit_we;
            if (blit_we) begin
                fb_addr <= blit_addr;
                fb_data <= blit_data;
            end
        end
    end

endmodule
